// File: rtl/cfu_pkg.sv
// ---------------------------------------------------------------------------
// cfu_pkg
// Shared types and helpers for the CFU blocks.
//   cfu_status_t            : response status returned with every result
//   popcount_func_t         : function codes of popcount_pipe_cfu
//   popcount_pipe_params_ok : elaboration-time parameter sanity check
// ---------------------------------------------------------------------------
package cfu_pkg;

   typedef enum logic [1:0] {
      CFU_OK       = 2'd0,
      CFU_ERROR_OP = 2'd1
   } cfu_status_t;

   typedef enum logic [2:0] {
      POP       = 3'd0,
      POP_AND   = 3'd1,
      HAM       = 3'd2,
      BYTEPOP   = 3'd3,
      ACC       = 3'd4,
      ACC_RDCLR = 3'd5
   } popcount_func_t;

   // True when the popcount pipeline can be built with these settings.
   function automatic bit popcount_pipe_params_ok(input int data_w,
                                                  input int latency,
                                                  input int func_id_w);
      return ((data_w == 32) || (data_w == 64)) &&
             (latency >= 1) && (latency <= 3) &&
             (func_id_w >= 3);
   endfunction

endpackage

// File: rtl/byte_popcount.sv
// ---------------------------------------------------------------------------
// byte_popcount
// Combinational count of set bits in one byte.
//   i_byte  : byte to count
//   o_count : number of ones in i_byte (0..8)
// ---------------------------------------------------------------------------
module byte_popcount (
   input  logic [7:0] i_byte,
   output logic [3:0] o_count
);

   always_comb begin
      o_count = '0;
      for (int i = 0; i < 8; i++) begin
         o_count = o_count + {3'b000, i_byte[i]};
      end
   end

endmodule

// File: rtl/popcount_pipe_cfu.sv
// ---------------------------------------------------------------------------
// popcount_pipe_cfu
// Pipelined bit-count custom function unit with valid/ready on request and
// response. Functions: POP, POP_AND, HAM, BYTEPOP, ACC, ACC_RDCLR; codes 6/7
// (and any higher code) answer CFU_ERROR_OP. LATENCY (1..3) cycles from
// accept to response valid, one op per cycle, in order.
//   clk, rst_n                   : clock, asynchronous active-low reset
//   req_valid/req_ready          : request handshake (req_ready = advance)
//   req_cfu                      : CFU id, ignored
//   req_func                     : function code
//   req_data0/req_data1          : operands
//   resp_valid/resp_ready        : response handshake
//   resp_status/resp_data        : result, held while stalled
// ---------------------------------------------------------------------------
module popcount_pipe_cfu
   import cfu_pkg::*;
#(
   parameter int CFU_VERSION    = 100,
   parameter int CFU_CFU_ID_MAX = 1,
   parameter int CFU_CFU_ID_W   = 0,
   parameter int CFU_FUNC_ID_W  = 3,
   parameter int CFU_DATA_W     = 32,
   parameter int LATENCY        = 2
) (
   input  logic                                                  clk,
   input  logic                                                  rst_n,
   input  logic                                                  req_valid,
   output logic                                                  req_ready,
   input  logic [((CFU_CFU_ID_W > 0) ? CFU_CFU_ID_W : 1)-1:0]    req_cfu,
   input  logic [CFU_FUNC_ID_W-1:0]                              req_func,
   input  logic [CFU_DATA_W-1:0]                                 req_data0,
   input  logic [CFU_DATA_W-1:0]                                 req_data1,
   output logic                                                  resp_valid,
   input  logic                                                  resp_ready,
   output cfu_status_t                                           resp_status,
   output logic [CFU_DATA_W-1:0]                                 resp_data
);

   localparam int NB = CFU_DATA_W / 8;   // bytes per operand
   localparam int NL = NB / 2;           // 16-bit lanes per operand

   if (!popcount_pipe_params_ok(CFU_DATA_W, LATENCY, CFU_FUNC_ID_W)) begin : g_bad_params
      $error("popcount_pipe_cfu: CFU_DATA_W must be 32/64, LATENCY 1..3, CFU_FUNC_ID_W >= 3");
   end

   // Interface-level settings with no effect on the datapath.
   localparam int unused_cfg = CFU_VERSION + CFU_CFU_ID_MAX;
   logic w_unused_cfu;
   assign w_unused_cfu = ^req_cfu;

   // Single global advance: every stage moves together or holds together,
   // so bubbles never collapse during a stall.
   logic r_resp_valid;
   logic w_en;
   assign w_en      = !r_resp_valid || resp_ready;
   assign req_ready = w_en;

   // ---------------- S1: decode, operand select, byte counts ----------------
   popcount_func_t            w_s1_op;
   logic                      w_s1_err;
   logic [CFU_DATA_W-1:0]     w_sel;
   logic [4*NB-1:0]           w_s1_cnt;

   // NOTE: every output gets a default before the case so no latch is inferred.
   always_comb begin
      w_s1_op  = POP;
      w_s1_err = 1'b0;
      w_sel    = req_data0;
      if (req_func > CFU_FUNC_ID_W'(5)) begin
         w_s1_err = 1'b1;
      end else begin
         w_s1_op = popcount_func_t'(req_func[2:0]);
         case (w_s1_op)
            POP_AND: w_sel = req_data0 & req_data1;
            HAM:     w_sel = req_data0 ^ req_data1;
            default: ;
         endcase
      end
   end

   for (genvar g = 0; g < NB; g++) begin : g_byte
      byte_popcount u_byte_popcount (
         .i_byte  (w_sel[8*g +: 8]),
         .o_count (w_s1_cnt[4*g +: 4])
      );
   end

   // ---------------- Stage A: byte counts registered (LATENCY >= 2) ---------
   logic                      w_a_valid;
   logic                      w_a_err;
   popcount_func_t            w_a_op;
   logic [4*NB-1:0]           w_a_cnt;

   if (LATENCY >= 2) begin : g_stage_a
      logic            r_valid;
      logic            r_err;
      popcount_func_t  r_op;
      logic [4*NB-1:0] r_cnt;

      // NOTE: sequential state uses non-blocking assignments only.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_op    <= POP;
            r_cnt   <= '0;
         end else if (w_en) begin
            r_valid <= req_valid;
            r_err   <= w_s1_err;
            r_op    <= w_s1_op;
            r_cnt   <= w_s1_cnt;
         end
      end

      assign w_a_valid = r_valid;
      assign w_a_err   = r_err;
      assign w_a_op    = r_op;
      assign w_a_cnt   = r_cnt;
   end else begin : g_no_stage_a
      assign w_a_valid = req_valid;
      assign w_a_err   = w_s1_err;
      assign w_a_op    = w_s1_op;
      assign w_a_cnt   = w_s1_cnt;
   end

   // 16-bit lane sums: two byte counts each, max 16 fits in 5 bits.
   logic [5*NL-1:0] w_a_lane;
   always_comb begin
      w_a_lane = '0;
      for (int l = 0; l < NL; l++) begin
         w_a_lane[5*l +: 5] = {1'b0, w_a_cnt[8*l +: 4]} + {1'b0, w_a_cnt[8*l+4 +: 4]};
      end
   end

   // ---------------- Stage B: lane sums registered (LATENCY == 3) -----------
   logic                      w_b_valid;
   logic                      w_b_err;
   popcount_func_t            w_b_op;
   logic [4*NB-1:0]           w_b_cnt;
   logic [5*NL-1:0]           w_b_lane;

   if (LATENCY == 3) begin : g_stage_b
      logic            r_valid;
      logic            r_err;
      popcount_func_t  r_op;
      logic [4*NB-1:0] r_cnt;   // still needed for BYTEPOP
      logic [5*NL-1:0] r_lane;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_op    <= POP;
            r_cnt   <= '0;
            r_lane  <= '0;
         end else if (w_en) begin
            r_valid <= w_a_valid;
            r_err   <= w_a_err;
            r_op    <= w_a_op;
            r_cnt   <= w_a_cnt;
            r_lane  <= w_a_lane;
         end
      end

      assign w_b_valid = r_valid;
      assign w_b_err   = r_err;
      assign w_b_op    = r_op;
      assign w_b_cnt   = r_cnt;
      assign w_b_lane  = r_lane;
   end else begin : g_no_stage_b
      assign w_b_valid = w_a_valid;
      assign w_b_err   = w_a_err;
      assign w_b_op    = w_a_op;
      assign w_b_cnt   = w_a_cnt;
      assign w_b_lane  = w_a_lane;
   end

   // ---------------- Final stage: total, function mux, accumulator ----------
   logic [6:0]            w_total;
   logic [CFU_DATA_W-1:0] w_total_ext;
   logic [CFU_DATA_W-1:0] w_res;
   logic [CFU_DATA_W-1:0] w_acc_next;
   cfu_status_t           w_status;
   logic [CFU_DATA_W-1:0] r_acc;
   logic [CFU_DATA_W-1:0] r_resp_data;
   cfu_status_t           r_resp_status;

   always_comb begin
      w_total = '0;
      for (int l = 0; l < NL; l++) begin
         w_total = w_total + 7'(w_b_lane[5*l +: 5]);
      end
   end

   always_comb begin
      w_total_ext = CFU_DATA_W'(w_total);
      w_res       = w_total_ext;
      w_acc_next  = r_acc;
      w_status    = CFU_OK;
      if (w_b_err) begin
         w_res    = '0;
         w_status = CFU_ERROR_OP;
      end else begin
         case (w_b_op)
            BYTEPOP: begin
               for (int k = 0; k < NB; k++) begin
                  w_res[8*k +: 8] = {4'b0000, w_b_cnt[4*k +: 4]};
               end
            end
            ACC: begin
               w_acc_next = r_acc + w_total_ext;
               w_res      = w_acc_next;
            end
            ACC_RDCLR: begin
               w_res      = r_acc;
               w_acc_next = '0;
            end
            default: ;
         endcase
      end
   end

   // The accumulator moves only when its op is loaded into the output
   // register, so a held (stalled) op can never be applied twice.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_resp_valid  <= 1'b0;
         r_resp_data   <= '0;
         r_resp_status <= CFU_OK;
         r_acc         <= '0;
      end else if (w_en) begin
         r_resp_valid <= w_b_valid;
         if (w_b_valid) begin
            r_resp_data   <= w_res;
            r_resp_status <= w_status;
            r_acc         <= w_acc_next;
         end
      end
   end

   assign resp_valid  = r_resp_valid;
   assign resp_data   = r_resp_data;
   assign resp_status = r_resp_status;

endmodule

// File: tb/tb_popcount_pipe_cfu.sv
// ---------------------------------------------------------------------------
// tb_popcount_pipe_cfu
// Two instances share one request bus: u_dut32 (32-bit, LATENCY=2) and
// u_dut64 (64-bit, LATENCY=3). Each has its own resp_ready. A negedge
// monitor per instance predicts every accepted request with a plain
// arithmetic model and compares every consumed response; the initial block
// runs directed scenarios with constant expectations, then random traffic.
// ---------------------------------------------------------------------------
module tb_popcount_pipe_cfu;
   import cfu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        req_valid = 1'b0;
   logic [2:0]  req_func = '0;
   logic [63:0] req_d0 = '0;
   logic [63:0] req_d1 = '0;
   logic [0:0]  req_cfu = '0;

   logic        req_ready32, resp_valid32;
   logic        resp_ready32 = 1'b1;
   cfu_status_t resp_status32;
   logic [31:0] resp_data32;

   logic        req_ready64, resp_valid64;
   logic        resp_ready64 = 1'b1;
   cfu_status_t resp_status64;
   logic [63:0] resp_data64;

   int total = 0;
   int bad   = 0;

   popcount_pipe_cfu #(.CFU_DATA_W(32), .LATENCY(2)) u_dut32 (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready32),
      .req_cfu     (req_cfu),
      .req_func    (req_func),
      .req_data0   (req_d0[31:0]),
      .req_data1   (req_d1[31:0]),
      .resp_valid  (resp_valid32),
      .resp_ready  (resp_ready32),
      .resp_status (resp_status32),
      .resp_data   (resp_data32)
   );

   popcount_pipe_cfu #(.CFU_DATA_W(64), .LATENCY(3)) u_dut64 (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready64),
      .req_cfu     (req_cfu),
      .req_func    (req_func),
      .req_data0   (req_d0),
      .req_data1   (req_d1),
      .resp_valid  (resp_valid64),
      .resp_ready  (resp_ready64),
      .resp_status (resp_status64),
      .resp_data   (resp_data64)
   );

   typedef struct {
      logic [63:0] data;
      cfu_status_t st;
   } resp_t;

   resp_t       exp32[$], obs32[$], exp64[$], obs64[$];
   resp_t       e32, e64, o32, o64;
   logic [63:0] acc32_m = '0, acc64_m = '0, acc_tmp32, acc_tmp64;

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Reference behaviour: popcounts straight from the function definitions.
   function automatic resp_t model(input int w, input logic [2:0] f,
                                   input logic [63:0] d0, input logic [63:0] d1,
                                   input logic [63:0] acc_in, output logic [63:0] acc_out);
      resp_t       r;
      logic [63:0] mask, a, b, sel;
      int          ones;
      mask = (w == 64) ? {64{1'b1}} : 64'h0000_0000_FFFF_FFFF;
      a    = d0 & mask;
      b    = d1 & mask;
      sel  = (f == 3'd1) ? (a & b) : (f == 3'd2) ? (a ^ b) : a;
      ones = $countones(sel);
      r.st    = CFU_OK;
      r.data  = 64'(ones);
      acc_out = acc_in;
      case (f)
         3'd3: begin
            r.data = '0;
            for (int k = 0; k < w/8; k++) r.data[8*k +: 8] = 8'($countones(a[8*k +: 8]));
         end
         3'd4: begin
            acc_out = (acc_in + 64'(ones)) & mask;
            r.data  = acc_out;
         end
         3'd5: begin
            r.data  = acc_in;
            acc_out = '0;
         end
         3'd6, 3'd7: begin
            r.st   = CFU_ERROR_OP;
            r.data = '0;
         end
         default: ;
      endcase
      return r;
   endfunction

   // ---------------- monitors / scoreboards ----------------
   always @(negedge clk) begin
      if (!rst_n) begin
         exp32.delete();
         obs32.delete();
         acc32_m = '0;
      end else begin
         if (resp_valid32 && resp_ready32) begin
            o32.data = 64'(resp_data32);
            o32.st   = resp_status32;
            obs32.push_back(o32);
            check("resp32_was_expected", 64'(exp32.size() > 0), 64'd1);
            if (exp32.size() > 0) begin
               e32 = exp32.pop_front();
               check("resp32_data", 64'(resp_data32), e32.data);
               check("resp32_status", 64'(resp_status32), 64'(e32.st));
            end
         end
         if (req_valid && req_ready32) begin
            exp32.push_back(model(32, req_func, req_d0, req_d1, acc32_m, acc_tmp32));
            acc32_m = acc_tmp32;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         exp64.delete();
         obs64.delete();
         acc64_m = '0;
      end else begin
         if (resp_valid64 && resp_ready64) begin
            o64.data = resp_data64;
            o64.st   = resp_status64;
            obs64.push_back(o64);
            check("resp64_was_expected", 64'(exp64.size() > 0), 64'd1);
            if (exp64.size() > 0) begin
               e64 = exp64.pop_front();
               check("resp64_data", resp_data64, e64.data);
               check("resp64_status", 64'(resp_status64), 64'(e64.st));
            end
         end
         if (req_valid && req_ready64) begin
            exp64.push_back(model(64, req_func, req_d0, req_d1, acc64_m, acc_tmp64));
            acc64_m = acc_tmp64;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] f, input logic [63:0] d0, input logic [63:0] d1);
      req_valid = 1'b1;
      req_func  = f;
      req_d0    = d0;
      req_d1    = d1;
   endtask

   task automatic idle();
      req_valid = 1'b0;
      req_func  = '0;
      req_d0    = '0;
      req_d1    = '0;
   endtask

   task automatic drain();
      idle();
      repeat (8) tick();
      obs32.delete();
      obs64.delete();
   endtask

   // Next consumed response of one instance, bounded wait.
   task automatic get_resp(input bit wide, output resp_t r);
      int n;
      n = 0;
      while (((wide ? obs64.size() : obs32.size()) == 0) && (n < 30)) begin
         @(negedge clk);
         n++;
      end
      check(wide ? "resp64_arrived" : "resp32_arrived",
            64'((wide ? obs64.size() : obs32.size()) > 0), 64'd1);
      if (wide && (obs64.size() > 0))       r = obs64.pop_front();
      else if (!wide && (obs32.size() > 0)) r = obs32.pop_front();
      else begin
         r.data = 'x;
         r.st   = CFU_ERROR_OP;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog elapsed=%0t limit=2000000", $time);
      $fatal(1, "watchdog");
   end

   // ---------------- directed + random sequence ----------------
   initial begin
      resp_t r;
      int    n;

      // Reset state
      @(negedge clk);
      check("rst_resp_valid32", 64'(resp_valid32), 64'd0);
      check("rst_resp_data32", 64'(resp_data32), 64'd0);
      check("rst_resp_status32", 64'(resp_status32), 64'(CFU_OK));
      check("rst_resp_valid64", 64'(resp_valid64), 64'd0);
      check("rst_req_ready32", 64'(req_ready32), 64'd1);
      tick();
      rst_n = 1'b1;
      tick();

      // Back-to-back POP / POP_AND / HAM, exact latency on the 32-bit unit
      drive(3'd0, 64'hFFFF_FFFF, 64'h0);
      tick();
      drive(3'd1, 64'hF0F0_F0F0, 64'hFF00_FF00);
      @(negedge clk);
      check("lat_t1_valid", 64'(resp_valid32), 64'd0);
      tick();
      drive(3'd2, 64'hAAAA_AAAA, 64'h5555_5555);
      @(negedge clk);
      check("lat_t2_valid", 64'(resp_valid32), 64'd1);
      check("pop_all_ones", 64'(resp_data32), 64'd32);
      check("pop_status", 64'(resp_status32), 64'(CFU_OK));
      tick();
      idle();
      @(negedge clk);
      check("lat_t3_valid", 64'(resp_valid32), 64'd1);
      check("pop_and", 64'(resp_data32), 64'd8);
      tick();
      @(negedge clk);
      check("lat_t4_valid", 64'(resp_valid32), 64'd1);
      check("ham", 64'(resp_data32), 64'd32);
      check("ham_status", 64'(resp_status32), 64'(CFU_OK));
      tick();
      @(negedge clk);
      check("lat_t5_idle", 64'(resp_valid32), 64'd0);
      drain();

      // BYTEPOP
      drive(3'd3, 64'h0103_07FF, 64'h0);
      tick();
      idle();
      get_resp(1'b0, r);
      check("bytepop32", r.data, 64'h0102_0308);
      check("bytepop32_status", 64'(r.st), 64'(CFU_OK));
      get_resp(1'b1, r);
      check("bytepop64", r.data, 64'h0000_0000_0102_0308);
      drain();

      // POP of all ones on both widths
      drive(3'd0, {64{1'b1}}, 64'h0);
      tick();
      idle();
      get_resp(1'b1, r);
      check("pop64_all_ones", r.data, 64'd64);
      get_resp(1'b0, r);
      check("pop32_low_half", r.data, 64'd32);
      drain();

      // Accumulator chain
      drive(3'd4, 64'hF, 64'h0);  tick();
      drive(3'd4, 64'hFF, 64'h0); tick();
      drive(3'd4, 64'h1, 64'h0);  tick();
      idle();
      get_resp(1'b0, r); check("acc_1", r.data, 64'd4);
      get_resp(1'b0, r); check("acc_2", r.data, 64'd12);
      get_resp(1'b0, r); check("acc_3", r.data, 64'd13);
      check("acc_status", 64'(r.st), 64'(CFU_OK));
      drive(3'd5, 64'h0, 64'h0);  tick();
      drive(3'd4, 64'h3, 64'h0);  tick();
      idle();
      get_resp(1'b0, r); check("acc_rdclr", r.data, 64'd13);
      get_resp(1'b0, r); check("acc_after_clr", r.data, 64'd2);
      drain();

      // Unimplemented function leaves the accumulator alone
      drive(3'd6, 64'hFFFF_FFFF, 64'h0); tick();
      drive(3'd5, 64'h0, 64'h0);         tick();
      idle();
      get_resp(1'b0, r);
      check("err_status", 64'(r.st), 64'(CFU_ERROR_OP));
      check("err_data", r.data, 64'd0);
      get_resp(1'b0, r);
      check("err_acc_kept", r.data, 64'd2);
      drain();

      // Backpressure on the LATENCY=3 unit (accumulator is 0 here)
      drive(3'd4, 64'h1, 64'h0); tick();
      drive(3'd4, 64'h3, 64'h0); tick();
      drive(3'd4, 64'h7, 64'h0); tick();
      resp_ready64 = 1'b0;
      drive(3'd4, 64'hF, 64'h0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("stall_req_ready", 64'(req_ready64), 64'd0);
         check("stall_resp_valid", 64'(resp_valid64), 64'd1);
         check("stall_resp_data", resp_data64, 64'd1);
         tick();
      end
      resp_ready64 = 1'b1;
      tick();
      idle();
      get_resp(1'b1, r); check("bp_resp_1", r.data, 64'd1);
      get_resp(1'b1, r); check("bp_resp_2", r.data, 64'd3);
      get_resp(1'b1, r); check("bp_resp_3", r.data, 64'd6);
      get_resp(1'b1, r); check("bp_resp_4", r.data, 64'd10);
      drive(3'd5, 64'h0, 64'h0); tick();
      idle();
      get_resp(1'b1, r); check("bp_acc_once", r.data, 64'd10);
      drain();

      // Reset with ops in flight and acc=5
      drive(3'd5, 64'h0, 64'h0); tick();
      drain();
      drive(3'd4, 64'h1F, 64'h0); tick();
      idle();
      get_resp(1'b0, r); check("pre_rst_acc32", r.data, 64'd5);
      get_resp(1'b1, r); check("pre_rst_acc64", r.data, 64'd5);
      drive(3'd4, 64'h1, 64'h0); tick();
      drive(3'd4, 64'h1, 64'h0); tick();
      idle();
      rst_n = 1'b0;
      #1;
      check("rst_drop_valid32", 64'(resp_valid32), 64'd0);
      check("rst_drop_valid64", 64'(resp_valid64), 64'd0);
      check("rst_drop_data32", 64'(resp_data32), 64'd0);
      @(negedge clk);
      tick();
      rst_n = 1'b1;
      drive(3'd5, 64'h0, 64'h0); tick();
      idle();
      get_resp(1'b0, r); check("post_rst_acc32", r.data, 64'd0);
      get_resp(1'b1, r); check("post_rst_acc64", r.data, 64'd0);
      repeat (8) tick();
      check("no_stale32", 64'(obs32.size()), 64'd0);
      check("no_stale64", 64'(obs64.size()), 64'd0);

      // Random traffic with random backpressure
      for (int i = 0; i < 400; i++) begin
         req_valid    = ($urandom_range(0, 3) != 0);
         req_func     = 3'($urandom_range(0, 7));
         req_d0       = {$urandom, $urandom};
         req_d1       = {$urandom, $urandom};
         resp_ready32 = ($urandom_range(0, 3) != 0);
         resp_ready64 = ($urandom_range(0, 3) != 0);
         tick();
      end
      idle();
      resp_ready32 = 1'b1;
      resp_ready64 = 1'b1;
      n = 0;
      while (((exp32.size() != 0) || (exp64.size() != 0)) && (n < 100)) begin
         tick();
         n++;
      end
      check("final_drain32", 64'(exp32.size()), 64'd0);
      check("final_drain64", 64'(exp64.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
